// File: rtl/pixel_reducer_pkg.sv
// rtl/pixel_reducer_pkg.sv - shared widths, FSM state codes and sample quantiser
package pixel_reducer_pkg;

    localparam int PIX_W_DEF  = 8;
    localparam int DATA_W_DEF = 4;
    localparam int DEPTH_DEF  = 32;
    localparam int ADDR_W_DEF = $clog2(DEPTH_DEF);

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ARMED = 2'd1;
    localparam state_t ST_ACCUM = 2'd2;
    localparam state_t ST_HOLD  = 2'd3;

    // Keep the top DATA_W bits of the pair sum, i.e. the truncated average.
    function automatic logic [DATA_W_DEF-1:0] quantise(input logic [PIX_W_DEF:0] sum);
        return DATA_W_DEF'(sum >> (PIX_W_DEF + 1 - DATA_W_DEF));
    endfunction

endpackage

// File: rtl/pix_pair_accum.sv
// rtl/pix_pair_accum.sv - holds the first pixel of a pair and presents the pair sum
module pix_pair_accum #(
    parameter int PIX_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             drop,
    input  logic             in_valid,
    input  logic [PIX_W-1:0] in_data,
    output logic [PIX_W:0]   sum,
    output logic             sum_valid
);

    logic [PIX_W-1:0] held;
    logic             have;

    assign sum       = {1'b0, held} + {1'b0, in_data};
    assign sum_valid = in_valid && have && !clear && !drop;

    // clear restarts pairing with the same-cycle pixel as first; drop discards everything
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held <= '0;
            have <= 1'b0;
        end else if (drop) begin
            have <= 1'b0;
        end else if (clear) begin
            have <= in_valid;
            held <= in_data;
        end else if (in_valid) begin
            if (have) begin
                have <= 1'b0;
            end else begin
                have <= 1'b1;
                held <= in_data;
            end
        end
    end

endmodule

// File: rtl/pixel_reducer.sv
// rtl/pixel_reducer.sv - pixel-pair averaging line capture into a 32x4 line RAM
module pixel_reducer
    import pixel_reducer_pkg::*;
#(
    parameter int PIX_W  = PIX_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int DECIM  = 2,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              vsync,
    input  logic              href,
    input  logic              pix_valid,
    input  logic [PIX_W-1:0]  pix_data,
    input  logic              line_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_wr,
    output logic              line_done,
    output logic [ADDR_W:0]   line_len,
    output logic              overflow
);

    if (DECIM != 2) begin : g_decim_check
        $error("pixel_reducer supports DECIM=2 only");
    end

    localparam logic [ADDR_W:0] LAST_SLOT = (ADDR_W+1)'(DEPTH - 1);

    state_t          state;
    logic [ADDR_W:0] slot;
    logic            done_pend;
    logic            accept;
    logic            pair_clear;
    logic            pair_drop;
    logic [PIX_W:0]  pair_sum;
    logic            pair_valid;

    assign accept     = href && pix_valid && !vsync &&
                        (state == ST_ACCUM || state == ST_ARMED);
    assign pair_clear = (state == ST_ARMED) && href && !vsync;
    assign pair_drop  = vsync || (state == ST_ACCUM && !href);

    pix_pair_accum #(.PIX_W(PIX_W)) u_pair (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (pair_clear),
        .drop     (pair_drop),
        .in_valid (accept),
        .in_data  (pix_data),
        .sum      (pair_sum),
        .sum_valid(pair_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            slot      <= '0;
            done_pend <= 1'b0;
            mem_addr  <= '0;
            mem_din   <= '0;
            mem_wr    <= 1'b0;
            line_done <= 1'b0;
            line_len  <= '0;
            overflow  <= 1'b0;
        end else begin
            mem_wr    <= 1'b0;
            line_done <= done_pend;
            done_pend <= 1'b0;
            if (state == ST_HOLD && href && pix_valid) begin
                overflow <= 1'b1;
            end
            if (vsync && state != ST_IDLE) begin
                state <= ST_ARMED;
                slot  <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (vsync) state <= ST_ARMED;
                    end
                    ST_ARMED: begin
                        if (href) begin
                            state <= ST_ACCUM;
                            slot  <= '0;
                        end
                    end
                    ST_ACCUM: begin
                        if (!href) begin
                            state     <= ST_HOLD;
                            line_done <= 1'b1;
                            line_len  <= slot;
                        end else if (pair_valid) begin
                            mem_wr   <= 1'b1;
                            mem_addr <= slot[ADDR_W-1:0];
                            mem_din  <= quantise(pair_sum);
                            slot     <= slot + 1'b1;
                            // A full line hands over once the final write is visible
                            if (slot == LAST_SLOT) begin
                                state     <= ST_HOLD;
                                done_pend <= 1'b1;
                                line_len  <= slot + 1'b1;
                            end
                        end
                    end
                    default: begin
                        if (line_ack) state <= ST_ARMED;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pixel_reducer.sv
// tb/tb_pixel_reducer.sv - directed table-driven bench for pixel_reducer
module tb_pixel_reducer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       vsync = 1'b0;
    logic       href = 1'b0;
    logic       pix_valid = 1'b0;
    logic       line_ack = 1'b0;
    logic [7:0] pix_data = 8'h00;
    logic [4:0] mem_addr;
    logic [3:0] mem_din;
    logic       mem_wr;
    logic       line_done;
    logic [5:0] line_len;
    logic       overflow;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [4:0] addr;
        logic [3:0] din;
        int         cyc;
    } wr_t;

    typedef struct {
        logic [7:0] p0;
        logic [7:0] p1;
        logic [3:0] din;
    } vec_t;

    wr_t wr_q[$];
    int  done_q[$];

    pixel_reducer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .vsync    (vsync),
        .href     (href),
        .pix_valid(pix_valid),
        .pix_data (pix_data),
        .line_ack (line_ack),
        .mem_addr (mem_addr),
        .mem_din  (mem_din),
        .mem_wr   (mem_wr),
        .line_done(line_done),
        .line_len (line_len),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mem_wr === 1'b1) wr_q.push_back('{mem_addr, mem_din, cyc});
        if (line_done === 1'b1) begin
            done_q.push_back(cyc);
            check("done_without_wr", 32'(mem_wr), 32'd0);
        end
    end

    task automatic pix(input logic [7:0] d);
        @(negedge clk);
        vsync = 1'b0; line_ack = 1'b0;
        href = 1'b1; pix_valid = 1'b1; pix_data = d;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            href = 1'b0; pix_valid = 1'b0; vsync = 1'b0; line_ack = 1'b0;
        end
    endtask

    task automatic pulse_vsync();
        @(negedge clk);
        href = 1'b0; pix_valid = 1'b0; vsync = 1'b1;
        @(negedge clk);
        vsync = 1'b0;
    endtask

    task automatic pulse_ack();
        @(negedge clk);
        href = 1'b0; pix_valid = 1'b0; line_ack = 1'b1;
        @(negedge clk);
        line_ack = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_addr"}, 32'(mem_addr), 32'd0);
        check({tag, "_din"}, 32'(mem_din), 32'd0);
        check({tag, "_wr"}, 32'(mem_wr), 32'd0);
        check({tag, "_done"}, 32'(line_done), 32'd0);
        check({tag, "_len"}, 32'(line_len), 32'd0);
        check({tag, "_ovf"}, 32'(overflow), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[7];
        logic [7:0] p0;
        int fall_cyc;

        tbl[0] = '{8'hFF, 8'hFF, 4'hF};
        tbl[1] = '{8'h00, 8'h1F, 4'h0};
        tbl[2] = '{8'h7F, 8'h81, 4'h8};
        tbl[3] = '{8'h10, 8'h30, 4'h2};
        tbl[4] = '{8'hA0, 8'h60, 4'h8};
        tbl[5] = '{8'h3F, 8'h3F, 4'h3};
        tbl[6] = '{8'hC8, 8'hE0, 4'hD};

        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        idle_cycles(2);

        // Full line: 64 pixels of 0x10*i fill all 32 slots
        pulse_vsync();
        wr_q.delete(); done_q.delete();
        for (int i = 0; i < 64; i++) pix(8'(i * 16));
        idle_cycles(4);
        check("full_nwr", 32'(wr_q.size()), 32'd32);
        for (int k = 0; k < wr_q.size(); k++) begin
            p0 = 8'(k * 32);
            check($sformatf("full_addr%0d", k), 32'(wr_q[k].addr), 32'(k));
            check($sformatf("full_din%0d", k), 32'(wr_q[k].din),
                  32'(((2 * int'(p0) + 16) >> 5) & 15));
        end
        check("full_ndone", 32'(done_q.size()), 32'd1);
        if (done_q.size() == 1 && wr_q.size() == 32)
            check("full_done_cyc", 32'(done_q[0]), 32'(wr_q[31].cyc + 1));
        check("full_len", 32'(line_len), 32'd32);
        check("full_ovf", 32'(overflow), 32'd0);

        // Pixels while the RAM is held set overflow without writing
        pix(8'h55);
        pix(8'h66);
        idle_cycles(2);
        check("hold_nwr", 32'(wr_q.size()), 32'd32);
        check("hold_ovf", 32'(overflow), 32'd1);
        pulse_ack();

        // Table of pairs on the next line, restarting at address 0
        wr_q.delete(); done_q.delete();
        for (int i = 0; i < 7; i++) begin
            pix(tbl[i].p0);
            pix(tbl[i].p1);
        end
        idle_cycles(3);
        check("tbl_nwr", 32'(wr_q.size()), 32'd7);
        for (int i = 0; i < 7 && i < wr_q.size(); i++) begin
            check($sformatf("tbl_addr%0d", i), 32'(wr_q[i].addr), 32'(i));
            check($sformatf("tbl_din%0d", i), 32'(wr_q[i].din), 32'(tbl[i].din));
        end
        check("tbl_ndone", 32'(done_q.size()), 32'd1);
        if (done_q.size() == 1 && wr_q.size() == 7)
            check("tbl_done_cyc", 32'(done_q[0]), 32'(wr_q[6].cyc + 1));
        check("tbl_len", 32'(line_len), 32'd7);
        check("tbl_ovf_sticky", 32'(overflow), 32'd1);
        pulse_ack();

        // Nine pixels: odd one discarded when href drops
        wr_q.delete(); done_q.delete();
        for (int i = 0; i < 9; i++) pix(8'(i * 32));
        @(negedge clk);
        href = 1'b0; pix_valid = 1'b0;
        fall_cyc = cyc;
        idle_cycles(3);
        check("odd_nwr", 32'(wr_q.size()), 32'd4);
        if (wr_q.size() == 4) begin
            check("odd_din0", 32'(wr_q[0].din), 32'h1);
            check("odd_din1", 32'(wr_q[1].din), 32'h5);
            check("odd_din2", 32'(wr_q[2].din), 32'h9);
            check("odd_din3", 32'(wr_q[3].din), 32'hD);
            check("odd_addr3", 32'(wr_q[3].addr), 32'd3);
        end
        check("odd_ndone", 32'(done_q.size()), 32'd1);
        if (done_q.size() == 1)
            check("odd_done_cyc", 32'(done_q[0]), 32'(fall_cyc + 1));
        check("odd_len", 32'(line_len), 32'd4);
        pulse_ack();

        // vsync mid-line aborts without line_done; same-cycle pixel dropped
        wr_q.delete(); done_q.delete();
        for (int i = 0; i < 10; i++) pix(8'h40);
        @(negedge clk);
        vsync = 1'b1; href = 1'b1; pix_valid = 1'b1; pix_data = 8'hFF;
        idle_cycles(3);
        check("abort_nwr", 32'(wr_q.size()), 32'd5);
        check("abort_ndone", 32'(done_q.size()), 32'd0);
        wr_q.delete();
        pix(8'h00); pix(8'hFE); pix(8'h20); pix(8'h20);
        idle_cycles(3);
        check("restart_nwr", 32'(wr_q.size()), 32'd2);
        if (wr_q.size() == 2) begin
            check("restart_addr0", 32'(wr_q[0].addr), 32'd0);
            check("restart_din0", 32'(wr_q[0].din), 32'h7);
            check("restart_addr1", 32'(wr_q[1].addr), 32'd1);
            check("restart_din1", 32'(wr_q[1].din), 32'h2);
        end
        check("restart_ndone", 32'(done_q.size()), 32'd1);
        check("restart_len", 32'(line_len), 32'd2);
        pulse_ack();

        // Asynchronous reset while a write strobe is high
        wr_q.delete(); done_q.delete();
        pix(8'h10); pix(8'h10); pix(8'h10); pix(8'h10);
        @(posedge clk);
        #1;
        check("pre_rst_wr", 32'(mem_wr), 32'd1);
        check("pre_rst_addr", 32'(mem_addr), 32'd1);
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) pix(8'h80);
        idle_cycles(2);
        check("idle_nwr", 32'(wr_q.size()), 32'd1);
        check("idle_ndone", 32'(done_q.size()), 32'd0);
        pulse_vsync();
        pix(8'h80); pix(8'h80);
        idle_cycles(3);
        check("post_rst_nwr", 32'(wr_q.size()), 32'd2);
        if (wr_q.size() == 2) begin
            check("post_rst_addr", 32'(wr_q[1].addr), 32'd0);
            check("post_rst_din", 32'(wr_q[1].din), 32'h8);
        end
        check("post_rst_len", 32'(line_len), 32'd1);
        check("post_rst_ovf", 32'(overflow), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pixel_reducer.md
# pixel_reducer

Front-end capture stage of the reduced camera path. Takes the 8-bit greyscale pixel stream from the camera interface and averages each pair of adjacent pixels. It quantises each average to 4 bits and writes one reduced line of up to 32 samples into the downstream 32x4 line RAM. A line-done/ack handshake hands the RAM to the consumer, and the next line is not captured until the consumer releases it.

## Interface
Parameters:
- PIX_W, 8, input pixel width
- DATA_W, 4, stored sample width (top bits of the pair average)
- DEPTH, 32, RAM slots per line; ADDR_W = $clog2(DEPTH) = 5
- DECIM, 2, input pixels averaged per stored sample; fixed at 2 for this revision

Ports:
- clk  in  1  single clock; all logic on posedge
- rst_n  in  1  reset, asynchronous, active-low
- vsync  in  1  frame-start pulse, one cycle
- href  in  1  line-active level
- pix_valid  in  1  pix_data valid this cycle (only honoured while href=1)
- pix_data  in  PIX_W  greyscale pixel
- line_ack  in  1  consumer has finished reading the RAM; one-cycle pulse
- mem_addr  out  ADDR_W  RAM address
- mem_din  out  DATA_W  RAM write data
- mem_wr  out  1  RAM write strobe
- line_done  out  1  one-cycle pulse: line complete in RAM
- line_len  out  ADDR_W+1  samples written in the last line, 0..32; held until the next line starts
- overflow  out  1  sticky: a pixel arrived while the RAM was held; cleared only by reset

## Operation
- FSM states:
  - IDLE: after reset; waits for vsync.
  - ARMED: waits for href=1.
  - ACCUM: capturing the line.
  - HOLD: RAM owned by the consumer; waits for line_ack.
- Transitions:
  - IDLE -> ARMED on vsync.
  - ARMED -> ACCUM on href=1. Slot counter and pair register are cleared on entry, and a pixel valid in that same cycle is accepted.
  - ACCUM -> HOLD when slot 31 is written.
  - ACCUM -> HOLD when href is sampled 0. An unpaired pending pixel is discarded.
  - HOLD -> ARMED on line_ack.
- vsync in any state except IDLE: return to ARMED, clear the slot counter and pending pixel, and drop any pixel valid that cycle. vsync does not clear overflow.
- Accumulate:
  - The first pixel of a pair is registered.
  - On the second pixel, sum = p0 + p1 (PIX_W+1 bits, no overflow possible).
  - mem_din = sum[PIX_W:PIX_W+1-DATA_W], which for the defaults is sum[8:5], i.e. (p0+p1)/2 truncated to its top 4 bits.
- mem_addr = slot counter. The counter increments after each write and never wraps within a line; at most 32 writes per line.
- overflow sets on any cycle with href=1 and pix_valid=1 while in HOLD.
- In ACCUM after the 32nd slot, further pixels on the same line are not possible, because the FSM is already in HOLD. They count as overflow.
- pix_valid while href=0, or while in IDLE or ARMED, is ignored and does not set overflow.
- line_len: captured at the ACCUM->HOLD transition.
- A line of zero samples still produces line_done with line_len=0 (e.g. href high for a single pixel).

## Timing
- Reset values:
  - mem_addr=0, mem_din=0, mem_wr=0
  - line_done=0, line_len=0, overflow=0
  - state=IDLE, pair register empty
- Write latency: mem_wr, mem_addr and mem_din are registered and asserted together in the cycle after the second pixel of a pair is accepted. mem_wr is high for exactly one cycle per sample.
- line_done is asserted the cycle after the final mem_wr, or the cycle after href is sampled 0 if no write is pending. It is never asserted in the same cycle as mem_wr.
- href falling in the same cycle as a pair-completing pixel: the write still happens, and line_done follows one cycle later.
- line_ack outside HOLD is ignored.
- line_ack and vsync in the same cycle: vsync wins (the result is ARMED either way, but the counters are cleared).
- rst_n asserted mid-line: all outputs take their reset values immediately, and no partial write is issued.

## Structure
- Package pixel_reducer_pkg:
  - state enum (IDLE, ARMED, ACCUM, HOLD)
  - PIX_W, DATA_W, DEPTH and ADDR_W defaults
  - a quantise function (sum -> DATA_W bits)
- One sub-module, pix_pair_accum. It holds the pending pixel and produces sum/valid for a completed pair, with clear and drop inputs. The FSM, slot counter and RAM interface stay in the top.

## Test plan
- Reset, then vsync, href=1, 64 pixels with pix_data = 0x10*i mod 256 -> 32 writes to addresses 0..31 with mem_din = top 4 bits of the pair average. line_done fires once, the cycle after the write to address 31. line_len=32.
- Pair 0xFF,0xFF -> mem_din=0xF. Pair 0x00,0x1F -> 0x0. Pair 0x7F,0x81 -> 0x8.
- href high for 9 pixels then low -> 4 writes (addresses 0..3), the ninth pixel discarded, line_done the cycle after href is sampled 0, line_len=4.
- In HOLD, drive href=1 with pix_valid -> no mem_wr and overflow=1. line_ack, then a new line -> writes restart at address 0, and overflow stays 1 until rst_n.
- vsync mid-line after 10 pixels -> counter cleared. The next line writes from address 0, and there is no line_done for the aborted line.
- rst_n pulsed low mid-line -> every output reads 0 asynchronously, and the FSM waits in IDLE until vsync.
